alu_op_sequencer: RTL and testbench

Sequencing controller for the 32-bit reversible ALU datapath (add/sub, multiply, divide, CRC-32). It accepts one operation request over a valid/ready handshake and drives registered operands and opcode into the ALU. It raises per-unit enables for the clock-gating cells, waits an opcode-dependent settle latency, and captures the result and CRC. It then re-samples the CRC to detect a transient error and returns a tagged response over a second valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-in-flight sequencer for the reversible ALU datapath.
// Ports: req_* handshake in, alu_* operands/results, en_* gating, rsp_* out.
module alu_op_sequencer #(
  parameter int ADD_CYCLES = 1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int ERRCNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  input  logic [3:0]          req_opcode,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [3:0]          alu_opcode,
  input  logic [31:0]         alu_result,
  input  logic [31:0]         alu_crc,
  output logic                en_addsub,
  output logic                en_mul,
  output logic                en_div,
  output logic                en_crc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_result,
  output logic [31:0]         rsp_crc,
  output logic                rsp_err,
  output logic                rsp_illegal,
  output logic                rsp_dbz,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CHECK,
    RESP
  } state_t;

  localparam logic [3:0] OP_IDLE = 4'b1111;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [7:0] lat;
  logic       accept;
  logic       op_legal;
  logic       op_dbz;
  logic       op_direct;
  logic       crc_bad;

  // Request decode
  assign accept    = req_valid && req_ready;
  assign op_legal  = (req_opcode[3:2] == 2'b00);
  assign op_dbz    = (req_opcode == OP_DIV) &&
                     (req_b == 32'd0);
  assign op_direct = !op_legal || op_dbz;
  assign crc_bad   = (alu_crc != rsp_crc);

  // Counter preload is latency-1 so the
  // last EXEC cycle sees cnt==0.
  always_comb begin
    lat = 8'(ADD_CYCLES - 1);
    unique case (1'b1)
      req_opcode == OP_MUL:
        lat = 8'(MUL_CYCLES - 1);
      req_opcode == OP_DIV:
        lat = 8'(DIV_CYCLES - 1);
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = op_direct ? RESP : EXEC;
      end
      EXEC: begin
        if (cnt == 8'd0) state_nx = CHECK;
      end
      CHECK: state_nx = RESP;
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  // Datapath, enables and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= OP_IDLE;
      cnt         <= '0;
      en_addsub   <= 1'b0;
      en_mul      <= 1'b0;
      en_div      <= 1'b0;
      en_crc      <= 1'b0;
      rsp_result  <= '0;
      rsp_crc     <= '0;
      rsp_err     <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_dbz     <= 1'b0;
      err_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a <= req_a;
            alu_b <= req_b;
            cnt   <= lat;
            if (!op_legal) begin
              alu_opcode  <= OP_IDLE;
              rsp_illegal <= 1'b1;
              rsp_result  <= '0;
              rsp_crc     <= '0;
              rsp_err     <= 1'b0;
            end else if (op_dbz) begin
              alu_opcode <= OP_IDLE;
              rsp_dbz    <= 1'b1;
              rsp_result <= '1;
              rsp_crc    <= '0;
              rsp_err    <= 1'b0;
            end else begin
              alu_opcode <= req_opcode;
              en_addsub  <=
                (req_opcode[3:1] == 3'b000);
              en_mul <= (req_opcode == OP_MUL);
              en_div <= (req_opcode == OP_DIV);
            end
          end
        end
        EXEC: begin
          if (cnt == 8'd0) begin
            rsp_result <= alu_result;
            rsp_crc    <= alu_crc;
            en_crc     <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CHECK: begin
          // Re-sample against the captured
          // CRC to catch a transient flip.
          rsp_err   <= crc_bad;
          en_addsub <= 1'b0;
          en_mul    <= 1'b0;
          en_div    <= 1'b0;
          en_crc    <= 1'b0;
          if (crc_bad && (err_count != '1))
            err_count <= err_count +
                         ERRCNT_W'(1);
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_err     <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_dbz     <= 1'b0;
            alu_opcode  <= OP_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: random + directed bench with scoreboard queue.
// Ports: drives alu_op_sequencer, models the ALU, checks via a monitor.
module tb_alu_op_sequencer;

  localparam int EW = 4;
  localparam int NADD = 1;
  localparam int NMUL = 4;
  localparam int NDIV = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic [3:0]    req_opcode;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [3:0]    alu_opcode;
  logic [31:0]   alu_result;
  logic [31:0]   alu_crc;
  logic          en_addsub;
  logic          en_mul;
  logic          en_div;
  logic          en_crc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_result;
  logic [31:0]   rsp_crc;
  logic          rsp_err;
  logic          rsp_illegal;
  logic          rsp_dbz;
  logic          busy;
  logic [EW-1:0] err_count;

  alu_op_sequencer #(
    .ADD_CYCLES(NADD),
    .MUL_CYCLES(NMUL),
    .DIV_CYCLES(NDIV),
    .ERRCNT_W(EW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_opcode(req_opcode),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .alu_crc(alu_crc),
    .en_addsub(en_addsub),
    .en_mul(en_mul),
    .en_div(en_div),
    .en_crc(en_crc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_crc(rsp_crc),
    .rsp_err(rsp_err),
    .rsp_illegal(rsp_illegal),
    .rsp_dbz(rsp_dbz),
    .busy(busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [3:0]    op;
    int unsigned   t0;
    int unsigned   lat;
    logic [31:0]   res;
    logic [31:0]   crc;
    logic          err;
    logic          ill;
    logic          dbz;
    logic [EW-1:0] ecnt;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          have = 1'b0;
  bit          fault = 1'b0;
  bit          hold_low = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [EW-1:0] errcnt_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc32(
    input logic [31:0] d
  );
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return ~c;
  endfunction

  // Behavioural ALU seen by the sequencer;
  // fault flips CRC bit 0 while the CRC unit
  // is enabled.
  always_comb begin
    case (alu_opcode)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a * alu_b;
      4'd3: alu_result = (alu_b == 0) ?
              32'hFFFF_FFFF : alu_a / alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_crc = crc32(alu_result) ^
              {31'd0, fault && en_crc};
  end

  function automatic exp_t model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op,
    input bit          f
  );
    exp_t e;
    int   n;
    e.a = a; e.b = b; e.op = op;
    e.t0 = 0; e.ecnt = '0;
    e.ill = (op > 4'd3);
    e.dbz = (op == 4'd3) && (b == 0);
    e.err = 1'b0;
    e.crc = 32'd0;
    e.lat = 1;
    if (e.ill) begin
      e.res = 32'd0;
    end else if (e.dbz) begin
      e.res = 32'hFFFF_FFFF;
    end else begin
      case (op)
        4'd0: begin e.res = a + b; n = NADD; end
        4'd1: begin e.res = a - b; n = NADD; end
        4'd2: begin e.res = a * b; n = NMUL; end
        default: begin
          e.res = a / b; n = NDIV;
        end
      endcase
      e.crc = crc32(e.res);
      e.err = f;
      e.lat = n + 2;
    end
    return e;
  endfunction

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  // Consumer backpressure
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold_low ? 1'b0 :
                  ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t        it;
    int unsigned ph;
    int unsigned n;
    bit          lg;
    bit          idle;
    if (!rst_n) begin
      have = 1'b0;
    end else begin
      if (rsp_valid && !have) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 at cyc %0d",
                   cyc);
        end else begin
          cur  = q.pop_front();
          have = 1'b1;
          chk("rsp_latency", 64'(cyc),
              64'(cur.t0 + cur.lat));
          chk("rsp_result", 64'(rsp_result),
              64'(cur.res));
          chk("rsp_crc", 64'(rsp_crc),
              64'(cur.crc));
          chk("rsp_flags",
              64'({rsp_err, rsp_illegal, rsp_dbz}),
              64'({cur.err, cur.ill, cur.dbz}));
          chk("err_count", 64'(err_count),
              64'(cur.ecnt));
        end
      end else if (have) begin
        chk("rsp_hold",
            {rsp_valid, rsp_err, rsp_illegal,
             rsp_dbz, rsp_result},
            {1'b1, cur.err, cur.ill,
             cur.dbz, cur.res});
        chk("rsp_hold_crc", 64'(rsp_crc),
            64'(cur.crc));
      end

      idle = !have && (q.size() == 0 ||
                       cyc == q[0].t0);
      chk("req_ready", 64'(req_ready),
          64'(idle));
      chk("busy", 64'(busy), 64'(!idle));

      if (!have && q.size() != 0 &&
          cyc != q[0].t0) begin
        it = q[0];
        ph = cyc - it.t0;
        lg = !it.ill && !it.dbz;
        n  = it.lat - 2;
        chk("enables",
            64'({en_addsub, en_mul, en_div, en_crc}),
            64'({lg && ph <= n + 1 && it.op <= 1,
                 lg && ph <= n + 1 && it.op == 2,
                 lg && ph <= n + 1 && it.op == 3,
                 lg && ph == n + 1}));
        chk("alu_operands",
            {alu_a, alu_b},
            {it.a, it.b});
        chk("alu_opcode_exec", 64'(alu_opcode),
            64'(lg ? it.op : 4'hF));
      end else begin
        chk("enables_off",
            64'({en_addsub, en_mul, en_div, en_crc}),
            64'(0));
        if (have) begin
          lg = !cur.ill && !cur.dbz;
          chk("alu_opcode_resp", 64'(alu_opcode),
              64'(lg ? cur.op : 4'hF));
        end else begin
          chk("alu_opcode_idle", 64'(alu_opcode),
              64'(4'hF));
          chk("flags_idle",
              64'({rsp_err, rsp_illegal, rsp_dbz}),
              64'(0));
        end
      end

      if (have && rsp_valid && rsp_ready)
        have = 1'b0;
    end
  end

  task automatic issue(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op,
    input bit          f
  );
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    req_opcode = op;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 at cyc %0d",
               cyc);
      req_valid = 1'b0;
    end else begin
      e = model(a, b, op, f);
      e.t0 = cyc;
      if (e.err && errcnt_m != '1)
        errcnt_m = errcnt_m + 1'b1;
      e.ecnt = errcnt_m;
      fault = f;
      q.push_back(e);
      @(negedge clk);
      req_valid  = 1'b0;
      req_a      = $urandom;
      req_b      = $urandom;
      req_opcode = 4'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || have) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0 || have) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] b;
    int          r;
    int          n;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {alu_a, 28'd0, alu_opcode},
        {32'd0, 28'd0, 4'hF});
    chk("reset_rsp",
        {rsp_valid, rsp_err, rsp_illegal, rsp_dbz,
         en_addsub, en_mul, en_div, en_crc,
         busy, req_ready},
        64'b0000000001);
    chk("reset_regs", {rsp_result, rsp_crc},
        64'd0);
    chk("reset_errcnt", 64'(err_count), 64'd0);
    #2 rst_n = 1'b1;

    issue(32'd5, 32'd7, 4'd0, 1'b0);
    drain();

    hold_low = 1'b1;
    issue(32'd3, 32'd9, 4'd2, 1'b0);
    n = 0;
    while (!have && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    hold_low = 1'b0;
    drain();

    issue(32'd100, 32'd0, 4'd3, 1'b0);
    issue(32'd1, 32'd2, 4'b0101, 1'b0);
    issue(32'd9, 32'd4, 4'd1, 1'b1);
    drain();
    chk("errcnt_first", 64'(err_count), 64'd1);

    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 8) ? 4'(r % 4) :
                     4'($urandom_range(4, 15));
      b  = ($urandom_range(0, 6) == 0) ?
             32'd0 : $urandom;
      issue($urandom, b, op,
            $urandom_range(0, 4) == 0);
    end
    drain();

    for (int i = 0; i < 17; i++)
      issue($urandom, $urandom, 4'd0, 1'b1);
    drain();
    chk("errcnt_sat", 64'(err_count), 64'hF);

    issue(32'd1000, 32'd7, 4'd3, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    errcnt_m = '0;
    fault    = 1'b0;
    #1;
    chk("midrst_state",
        {busy, rsp_valid, en_div, en_crc,
         alu_opcode, err_count},
        {1'b0, 1'b0, 1'b0, 1'b0,
         4'hF, 4'h0});
    chk("midrst_alu", {alu_a, alu_b}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(32'd5, 32'd7, 4'd0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
